dm_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory strobes DM_cs/DM_r/DM_w.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_ram_sp.sv | 25 ++
 rtl/dm_responder.sv | 123 ++++++++++++
 tb/tb_dm_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM states, op codes,
// default base address and the byte-to-word offset helper.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } dm_state_e;

  typedef enum logic {
    OP_LD = 1'b0,
    OP_ST = 1'b1
  } dm_op_e;

  localparam logic [31:0] DM_BASE_ADDR = 32'h1001_0000;
  localparam int          DM_CNT_W     = 4;

  // Unsigned wrap-around: addresses below base land far out of range.
  function automatic logic [31:0] dm_word_offset(input logic [31:0] addr,
                                                 input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/dm_ram_sp.sv
// Single-port synchronous RAM, 32-bit words, registered (read-first) output.
// Contents are never cleared by reset.
module dm_ram_sp #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for CPU data-memory strobes: accepts one word load or
// store, serves it after WAIT_CYCLES, and holds the CPU via stall meanwhile.
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DM_cs,
  input  logic        DM_r,
  input  logic        DM_w,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        DM_ready,
  output logic        DM_err,
  output logic        stall
);

  dm_state_e             state_q, state_d;
  logic [DM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  dm_op_e                op_q, op_d;

  logic                  req;
  logic                  illegal;
  logic                  to_resp;
  logic [31:0]           off_words;
  logic                  ram_we;
  logic [31:0]           ram_rdata;

  assign req       = DM_cs & (DM_r | DM_w);
  assign off_words = dm_word_offset(DM_addr, BASE_ADDR);
  assign illegal   = (DM_r & DM_w) | (DM_addr[1:0] != 2'b00) |
                     ((off_words >> DEPTH_LOG2) != 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    to_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = DM_CNT_W'(WAIT_CYCLES);
          idx_d   = off_words[DEPTH_LOG2-1:0];
          wdata_d = DM_wdata;
          op_d    = DM_w ? OP_ST : OP_LD;
          if (illegal) begin
            state_d = ST_ERR;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            to_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - DM_CNT_W'(1);
        if (cnt_q == DM_CNT_W'(1)) begin
          state_d = ST_RESP;
          to_resp = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM access happens on the edge entering RESP, so the captured (or, with
  // zero wait, the live) address is presented during the cycle before it.
  assign ram_we = to_resp & (op_d == OP_ST);

  dm_ram_sp #(
    .ADDR_W(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (idx_d),
    .wdata (wdata_d),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdata_d = rdata_q;
    if (state_q == ST_RESP && op_q == OP_LD) begin
      rdata_d = ram_rdata;
    end else if (state_q == ST_ERR) begin
      rdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_LD;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  end

  assign DM_rdata = rdata_d;
  assign DM_ready = (state_q == ST_RESP) | (state_q == ST_ERR);
  assign DM_err   = (state_q == ST_ERR);
  assign stall    = ((state_q == ST_IDLE) & req) | (state_q == ST_BUSY);

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (WAIT_CYCLES=2 and 0) driven by
// directed and random transactions, checked against a word-array model.
module tb_dm_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          NW   = 1024;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        stall [2];

  logic [31:0] mem_m   [2][NW];
  logic [31:0] last_rd [2];
  int          pool    [16];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) u_w2 (
    .clk(clk), .rst_n(rst_n), .DM_cs(cs[0]), .DM_r(rd[0]), .DM_w(wr[0]),
    .DM_addr(addr[0]), .DM_wdata(wdata[0]), .DM_rdata(rdata[0]),
    .DM_ready(ready[0]), .DM_err(err[0]), .stall(stall[0])
  );

  dm_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_w0 (
    .clk(clk), .rst_n(rst_n), .DM_cs(cs[1]), .DM_r(rd[1]), .DM_w(wr[1]),
    .DM_addr(addr[1]), .DM_wdata(wdata[1]), .DM_rdata(rdata[1]),
    .DM_ready(ready[1]), .DM_err(err[1]), .stall(stall[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic bus_idle(input int d);
    @(negedge clk);
    cs[d] = 1'b0;
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  // One request; keep=1 leaves DM_cs/strobes asserted after acceptance.
  task automatic txn(input int d, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] wd, input bit keep);
    logic [31:0] off;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat;
    int          idx;
    int          lat;
    int          stalls;
    off     = a - BASE;
    exp_err = (r && w) || (a % 4 != 0) || (off / 4 >= 32'(NW));
    exp_lat = exp_err ? 1 : wait_of(d) + 1;
    idx     = exp_err ? 0 : int'(off / 4);
    if (exp_err) exp_rd = 32'd0;
    else if (w)  exp_rd = last_rd[d];
    else         exp_rd = mem_m[d][idx];

    @(negedge clk);
    cs[d] = 1'b1; rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
    lat = 0;
    stalls = 0;
    #1;
    chk("rdata_hold", d, rdata[d], last_rd[d]);
    forever begin
      if (ready[d] === 1'b1 || lat >= 40) break;
      if (stall[d] === 1'b1) stalls++;
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (!keep) begin
          cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
        end
        addr[d]  = $urandom;
        wdata[d] = $urandom;
      end
      #1;
    end
    chk("latency", d, 32'(lat), 32'(exp_lat));
    chk("stall_cycles", d, 32'(stalls), 32'(exp_lat));
    chk("stall_at_ready", d, 32'(stall[d]), 32'd0);
    chk("err", d, 32'(err[d]), 32'(exp_err));
    chk("rdata", d, rdata[d], exp_rd);
    if (!exp_err && w) mem_m[d][idx] = wd;
    last_rd[d] = exp_rd;
    $display("txn dut%0d r=%0d w=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             d, r, w, a, wd, err[d], rdata[d], lat);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = '0;
    end
    rst_n = 1'b0;
    #8;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, 32'(ready[d]), 32'd0);
      chk("reset_err", d, 32'(err[d]), 32'd0);
      chk("reset_rdata", d, rdata[d], 32'd0);
      chk("reset_stall", d, 32'(stall[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      // store then load
      txn(d, 1'b0, 1'b1, BASE + 32'd4, 32'hDEAD_BEEF, 1'b0);
      txn(d, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0);
      // misaligned accesses leave RAM alone
      txn(d, 1'b1, 1'b0, BASE + 32'd2, 32'd0, 1'b0);
      txn(d, 1'b0, 1'b1, BASE + 32'd6, 32'h1234_5678, 1'b0);
      txn(d, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0);
      // range boundaries
      txn(d, 1'b1, 1'b0, 32'h0FFF_FFFC, 32'd0, 1'b0);
      txn(d, 1'b1, 1'b0, BASE + 32'd4096, 32'd0, 1'b0);
      txn(d, 1'b0, 1'b1, BASE + 32'd4092, 32'hCAFE_F00D, 1'b0);
      txn(d, 1'b1, 1'b0, BASE + 32'd4092, 32'd0, 1'b0);
      // chip select held high across back-to-back requests
      txn(d, 1'b0, 1'b1, BASE + 32'd8, 32'hA5A5_0001, 1'b1);
      txn(d, 1'b0, 1'b1, BASE + 32'd12, 32'h5A5A_0002, 1'b1);
      txn(d, 1'b1, 1'b0, BASE + 32'd8, 32'd0, 1'b1);
      txn(d, 1'b1, 1'b0, BASE + 32'd12, 32'd0, 1'b0);
      // load and store strobes together
      txn(d, 1'b1, 1'b1, BASE + 32'd4, 32'h0BAD_0BAD, 1'b0);
      txn(d, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0);
    end

    // reset in the middle of a store on the slow instance
    txn(0, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0);
    @(negedge clk);
    cs[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = BASE + 32'd4; wdata[0] = 32'h0BAD_0BAD;
    @(negedge clk);
    cs[0] = 1'b0; wr[0] = 1'b0;
    #1;
    chk("busy_stall", 0, 32'(stall[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ready", 0, 32'(ready[0]), 32'd0);
    chk("async_err", 0, 32'(err[0]), 32'd0);
    chk("async_rdata", 0, rdata[0], 32'd0);
    chk("async_stall", 0, 32'(stall[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    txn(0, 1'b1, 1'b0, BASE + 32'd4, 32'd0, 1'b0);

    // random traffic over a small pool of words
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) begin
        pool[k] = $urandom_range(0, NW - 1);
        txn(d, 1'b0, 1'b1, BASE + 32'(pool[k] * 4), $urandom, 1'b0);
      end
      for (int n = 0; n < 40; n++) begin
        int          kind;
        int          p;
        bit          keep;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        p    = pool[$urandom_range(0, 15)];
        keep = 1'($urandom_range(0, 1));
        a    = BASE + 32'(p * 4);
        if (kind <= 3)      txn(d, 1'b1, 1'b0, a, 32'd0, keep);
        else if (kind <= 6) txn(d, 1'b0, 1'b1, a, $urandom, keep);
        else if (kind == 7) txn(d, 1'($urandom_range(0, 1)), 1'b1,
                                a + 32'($urandom_range(1, 3)), $urandom, keep);
        else if (kind == 8) begin
          if ($urandom_range(0, 1) == 1)
            txn(d, 1'b1, 1'b0, BASE - 32'($urandom_range(1, 100) * 4), 32'd0, keep);
          else
            txn(d, 1'b0, 1'b1, BASE + 32'd4096 + 32'($urandom_range(0, 1000) * 4),
                $urandom, keep);
        end
        else txn(d, 1'b1, 1'b1, a, $urandom, keep);
      end
      bus_idle(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
